reaction_timer: RTL and testbench

//  Measures the player's reaction time: ms elapsed from stimulus onset (delay-done level) to the first button press.

---
 rtl/reaction_timer.sv | 69 ++++++
 tb/tb_reaction_timer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// reaction_timer: measures ms from stimulus onset to the first synchronized button press,
// flagging false starts and timeouts; the verdict is held until start drops.
module reaction_timer #(
  parameter int TICK_DIV = 25000,
  parameter int MAX_MS = 9999,
  parameter int MS_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stimulus,
  input  logic            button,
  output logic            led_on,
  output logic            busy,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] MS_TOP = MS_W'(MAX_MS);
  typedef enum logic [2:0] {IDLE, WAIT_STIM, TIMING, RESULT, FALSE_START, TIMEOUT} state_t;
  state_t state, next;
  logic [2:0] sync;
  logic [PW-1:0] pre;
  logic [MS_W-1:0] ms;
  logic press, tick;
  // sync[2] is the previous synchronized level, so a button held through trial entry never counts
  assign press = sync[1] & ~sync[2];
  assign tick = pre == PRE_TOP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sync <= '0;
      pre <= '0;
      ms <= '0;
      {result_ms, result_valid, false_start, timeout} <= '0;
    end else begin
      state <= next;
      sync <= {sync[1:0], button};
      pre <= state == TIMING && !tick ? pre + 1'b1 : '0;
      ms <= state == TIMING ? ms + MS_W'(tick) : '0;
      if (state == IDLE && next == WAIT_STIM) {result_ms, result_valid, false_start, timeout} <= '0;
      if (state == WAIT_STIM && next == FALSE_START) false_start <= 1'b1;
      if (state == TIMING && next == RESULT) begin
        result_ms <= ms;
        result_valid <= 1'b1;
      end
      if (state == TIMING && next == TIMEOUT) begin
        result_ms <= MS_TOP;
        timeout <= 1'b1;
      end
    end
  // press outranks both stimulus arrival and the final timeout tick
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = start ? WAIT_STIM : IDLE;
      WAIT_STIM: next = !start ? IDLE : press ? FALSE_START : stimulus ? TIMING : WAIT_STIM;
      TIMING:    next = !start ? IDLE : press ? RESULT : tick && ms == MS_TOP - 1'b1 ? TIMEOUT : TIMING;
      default:   next = start ? state : IDLE;
    endcase
  end
  always_comb begin
    led_on = state == TIMING;
    busy = state == WAIT_STIM || state == TIMING;
  end
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed trials push expected verdicts/snapshots into a queue; a monitor
// pops and compares whenever a verdict flag rises or a snapshot is requested.
module tb_reaction_timer;
  logic clk = 0, rst_n = 1, start = 0, stimulus = 0, button = 0;
  logic led_on, busy, result_valid, false_start, timeout;
  logic [5:0] result_ms;
  logic probe = 0;
  logic prv = 0, pfs = 0, pto = 0;
  int n_vec = 0, n_err = 0;

  typedef struct {
    string name;
    bit verdict;
    logic [5:0] ms;
    logic rv, fs, to, led, busy;
  } exp_t;
  exp_t q[$];

  reaction_timer #(.TICK_DIV(10), .MAX_MS(50), .MS_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stimulus(stimulus), .button(button),
    .led_on(led_on), .busy(busy), .result_ms(result_ms), .result_valid(result_valid),
    .false_start(false_start), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(bit verdict);
    exp_t e;
    logic [10:0] got, req;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: output presented with nothing expected", verdict ? "verdict" : "probe");
      return;
    end
    e = q.pop_front();
    got = {result_ms, result_valid, false_start, timeout, led_on, busy};
    req = {e.ms, e.rv, e.fs, e.to, e.led, e.busy};
    if (e.verdict != verdict || got !== req) begin
      n_err++;
      $display("FAIL %s: got %s ms=%0d rv=%b fs=%b to=%b led=%b busy=%b, required %s ms=%0d rv=%b fs=%b to=%b led=%b busy=%b",
               e.name, verdict ? "verdict" : "probe", result_ms, result_valid, false_start, timeout, led_on, busy,
               e.verdict ? "verdict" : "probe", e.ms, e.rv, e.fs, e.to, e.led, e.busy);
    end
  endtask

  always @(negedge clk) begin
    if ((result_valid & ~prv) | (false_start & ~pfs) | (timeout & ~pto)) check(1'b1);
    if (probe) check(1'b0);
    prv <= result_valid;
    pfs <= false_start;
    pto <= timeout;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string name, bit verdict, int ms, bit rv, bit fs, bit to, bit led, bit bz);
    exp_t e;
    e.name = name; e.verdict = verdict; e.ms = 6'(ms);
    e.rv = rv; e.fs = fs; e.to = to; e.led = led; e.busy = bz;
    q.push_back(e);
    if (!verdict) begin
      probe = 1;
      @(negedge clk);
      #1 probe = 0;
    end
  endtask

  task automatic end_trial;
    button = 0; start = 0; stimulus = 0;
    tick(3);
  endtask

  initial begin
    #1 rst_n = 0;
    tick(3);
    rst_n = 1;
    expect_v("reset", 0, 0, 0, 0, 0, 0, 0);
    // normal: button sampled 123 clks after stimulus -> 12 ms
    start = 1; tick(3);
    expect_v("wait_stim", 0, 0, 0, 0, 0, 0, 1);
    stimulus = 1; tick(60);
    expect_v("timing", 0, 0, 0, 0, 0, 1, 1);
    tick(63); button = 1;
    expect_v("normal", 1, 12, 1, 0, 0, 0, 0);
    tick(10);
    expect_v("normal_hold", 0, 12, 1, 0, 0, 0, 0);
    button = 0; start = 0; tick(2);
    expect_v("idle_hold", 0, 12, 1, 0, 0, 0, 0);
    stimulus = 0; tick(2);
    // false start, later stimulus ignored
    start = 1; tick(3);
    button = 1; tick(2); button = 0;
    expect_v("false_start", 1, 0, 0, 1, 0, 0, 0);
    tick(6);
    stimulus = 1; tick(20);
    expect_v("false_hold", 0, 0, 0, 1, 0, 0, 0);
    end_trial();
    // press and stimulus on the same edge: press wins
    start = 1; tick(3);
    button = 1; tick(2); stimulus = 1;
    expect_v("press_stim", 1, 0, 0, 1, 0, 0, 0);
    tick(5);
    end_trial();
    // timeout
    start = 1; tick(3);
    stimulus = 1;
    expect_v("timeout", 1, 50, 0, 0, 1, 0, 0);
    tick(505);
    expect_v("timeout_hold", 0, 50, 0, 0, 1, 0, 0);
    end_trial();
    // press on the final tick: result with pre-increment ms
    start = 1; tick(3);
    stimulus = 1; tick(498); button = 1;
    expect_v("press_final_tick", 1, 49, 1, 0, 0, 0, 0);
    tick(6);
    end_trial();
    // button held through entry, then release and re-press
    button = 1; tick(5);
    start = 1; tick(5);
    expect_v("held_wait", 0, 0, 0, 0, 0, 0, 1);
    stimulus = 1; tick(20);
    expect_v("held_timing", 0, 0, 0, 0, 0, 1, 1);
    button = 0; tick(5); button = 1;
    expect_v("held_repress", 1, 2, 1, 0, 0, 0, 0);
    tick(6);
    end_trial();
    // abort 5 ms into timing, then re-arm
    start = 1; tick(3);
    stimulus = 1; tick(52);
    expect_v("abort_timing", 0, 0, 0, 0, 0, 1, 1);
    start = 0; tick(1);
    expect_v("abort", 0, 0, 0, 0, 0, 0, 0);
    stimulus = 0;
    start = 1; tick(2);
    expect_v("rearm", 0, 0, 0, 0, 0, 0, 1);
    // asynchronous reset mid-timing
    stimulus = 1; tick(30);
    expect_v("pre_reset", 0, 0, 0, 0, 0, 1, 1);
    rst_n = 0;
    expect_v("reset_async", 0, 0, 0, 0, 0, 0, 0);
    start = 0; stimulus = 0; tick(2);
    rst_n = 1;
    expect_v("post_reset", 0, 0, 0, 0, 0, 0, 0);
    tick(3);
    expect_v("idle_after", 0, 0, 0, 0, 0, 0, 0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
